// File: rtl/tri_mat_row_server.sv
// ---------------------------------------------------------------------------
// tri_mat_row_server
//
// Matrix store on the responder side of the row-request interface of a
// triangular matrix inverter. A lower-triangular complex matrix arrives as an
// element stream in row-major order (row r, columns 0..r). When the last
// element is in, the block pulses start_o and then serves full rows on request
// until the inverter finishes. The finish is the falling edge of busy_i, and
// it is reported with done_o.
//
// Ports
//   clk_i                 clock
//   rst_i                 asynchronous active-high reset
//   flush_i               synchronous abort back to EMPTY
//   ld_valid_i/ld_ready_o element stream handshake (ready is registered)
//   ld_data_i             element {imag, real}, 2*WIDTH bits
//   start_o               one-cycle start pulse to the inverter
//   busy_i                inverter busy level
//   mat_row_addr_i        requested row index
//   mat_row_addr_valid_i  request strobe
//   mat_row_o             row data, element j at [j*2*WIDTH +: 2*WIDTH]
//   mat_row_addr_o        echoed row index
//   mat_row_valid_o       row data valid, one cycle after the request
//   done_o                one-cycle pulse when the inversion has finished
//   req_err_o             sticky flag: a request arrived while in EMPTY
// ---------------------------------------------------------------------------
module tri_mat_row_server #(
    parameter int  SIZE  = 16,
    parameter int  WIDTH = 64,
    localparam int AW    = $clog2(SIZE),
    localparam int EW    = 2 * WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               ld_valid_i,
    output logic               ld_ready_o,
    input  logic [EW-1:0]      ld_data_i,
    output logic               start_o,
    input  logic               busy_i,
    input  logic [AW-1:0]      mat_row_addr_i,
    input  logic               mat_row_addr_valid_i,
    output logic [SIZE*EW-1:0] mat_row_o,
    output logic [AW-1:0]      mat_row_addr_o,
    output logic               mat_row_valid_o,
    output logic               done_o,
    output logic               req_err_o
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_START,
        ST_SERVE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     row_cnt;
    logic [AW-1:0]     col_cnt;
    logic [AW-1:0]     row_next;
    logic [AW-1:0]     col_next;
    logic              busy_seen;
    logic              busy_seen_next;
    logic              start_next;
    logic              done_next;
    logic              err_next;
    logic              wr_en;
    logic              last_beat;
    logic              rd_fire;
    logic [SIZE*EW-1:0] row_masked;

    // Only the lower triangle is ever written; the upper triangle is masked
    // on the way out instead of being cleared on load.
    logic [EW-1:0] storage [SIZE][SIZE];

    assign last_beat = (row_cnt == AW'(SIZE - 1)) && (col_cnt == AW'(SIZE - 1));
    assign rd_fire   = mat_row_addr_valid_i && !flush_i;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_next     = state;
        row_next       = row_cnt;
        col_next       = col_cnt;
        busy_seen_next = busy_seen;
        start_next     = 1'b0;
        done_next      = 1'b0;
        err_next       = req_err_o;
        wr_en          = 1'b0;

        case (state)
            ST_EMPTY: begin
                // ld_ready_o is high only in EMPTY, so the handshake alone
                // qualifies a beat.
                if (ld_valid_i && ld_ready_o) begin
                    wr_en = 1'b1;
                    if (last_beat) begin
                        state_next = ST_START;
                        row_next   = '0;
                        col_next   = '0;
                    end else if (col_cnt == row_cnt) begin
                        row_next = row_cnt + AW'(1);
                        col_next = '0;
                    end else begin
                        col_next = col_cnt + AW'(1);
                    end
                end
            end

            ST_START: begin
                start_next     = 1'b1;
                busy_seen_next = 1'b0;
                state_next     = ST_SERVE;
            end

            ST_SERVE: begin
                // Completion is a 1->0 transition of busy_i. A low busy_i
                // that has not yet been high only means the inverter has
                // not started.
                if (busy_i) begin
                    busy_seen_next = 1'b1;
                end else if (busy_seen) begin
                    done_next      = 1'b1;
                    busy_seen_next = 1'b0;
                    state_next     = ST_EMPTY;
                    row_next       = '0;
                    col_next       = '0;
                end
            end

            default: begin
                state_next = ST_EMPTY;
                row_next   = '0;
                col_next   = '0;
            end
        endcase

        if (mat_row_addr_valid_i && (state == ST_EMPTY)) begin
            err_next = 1'b1;
        end

        // Flush overrides everything, including a load beat in the same cycle.
        if (flush_i) begin
            state_next     = ST_EMPTY;
            row_next       = '0;
            col_next       = '0;
            busy_seen_next = 1'b0;
            start_next     = 1'b0;
            done_next      = 1'b0;
            err_next       = 1'b0;
            wr_en          = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_EMPTY;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples values from before this edge.
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Control and status registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_cnt    <= '0;
            col_cnt    <= '0;
            busy_seen  <= 1'b0;
            ld_ready_o <= 1'b0;
            start_o    <= 1'b0;
            done_o     <= 1'b0;
            req_err_o  <= 1'b0;
        end else begin
            row_cnt    <= row_next;
            col_cnt    <= col_next;
            busy_seen  <= busy_seen_next;
            ld_ready_o <= (state_next == ST_EMPTY);
            start_o    <= start_next;
            done_o     <= done_next;
            req_err_o  <= err_next;
        end
    end

    // -----------------------------------------------------------------------
    // Matrix storage
    // -----------------------------------------------------------------------
    // NOTE: the storage array has no reset. Its contents are meaningless
    // until loaded, and a reset would prevent mapping it onto RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            storage[row_cnt][col_cnt] <= ld_data_i;
        end
    end

    // Columns right of the diagonal read as zero, whatever storage holds.
    always_comb begin
        row_masked = '0;
        for (int j = 0; j < SIZE; j++) begin
            if (j <= int'(mat_row_addr_i)) begin
                row_masked[j*EW +: EW] = storage[mat_row_addr_i][j];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Row response register: fixed one-cycle latency. A write to the same row
    // at the same edge is not visible here, so the response holds the
    // pre-write contents.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mat_row_valid_o <= 1'b0;
            mat_row_addr_o  <= '0;
            mat_row_o       <= '0;
        end else begin
            mat_row_valid_o <= rd_fire;
            if (rd_fire) begin
                mat_row_addr_o <= mat_row_addr_i;
                mat_row_o      <= row_masked;
            end
        end
    end

endmodule

// File: doc/tri_mat_row_server.md
Name: tri_mat_row_server

Overview:
- Row-serving matrix store feeding `traing_matrix_inv`, i.e. the responder side of its row-request interface.
- Accepts a lower-triangular complex matrix as an element stream and issues a start pulse to the inverter.
- Answers each row-address request with the full row, fixed 1-cycle latency, and signals completion when the inverter drops busy.

Parameters:
- SIZE, 16, matrix dimension (rows = cols).
- WIDTH, 64, bits per real/imag part (IEEE double); one element = 2*WIDTH bits, {imag, real}.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous abort; returns block to EMPTY.
- ld_valid_i  in  1  load element valid.
- ld_ready_o  out  1  load element ready.
- ld_data_i  in  2*WIDTH  element {imag, real}; lower-triangle row-major order (row r, cols 0..r).
- start_o  out  1  one-cycle start pulse to inverter.
- busy_i  in  1  inverter busy.
- mat_row_addr_i  in  $clog2(SIZE)  requested row index.
- mat_row_addr_valid_i  in  1  request strobe.
- mat_row_o  out  SIZE*2*WIDTH  row data; element j at bits [j*2*WIDTH +: 2*WIDTH].
- mat_row_addr_o  out  $clog2(SIZE)  echoed row index.
- mat_row_valid_o  out  1  row data valid.
- done_o  out  1  one-cycle pulse when inversion finished.
- req_err_o  out  1  sticky; a request arrived outside START/SERVE.

Behaviour:
- Reset (rst_i=1, async):
  - All outputs 0, including ld_ready_o.
  - State EMPTY, load counters row=col=0, storage contents don't-care.
- ld_ready_o is registered. It rises the first clock after reset release or flush, and is 1 only in EMPTY.
- States:
  - EMPTY: accept beats while ld_valid_i & ld_ready_o.
    - Each beat writes storage[row][col].
    - Counter update: if col==row then row++, col=0; else col++.
    - After beat number SIZE*(SIZE+1)/2 (row==SIZE-1, col==SIZE-1), ld_ready_o drops the next cycle and state becomes START.
  - START: start_o=1 for exactly one cycle, then SERVE.
  - SERVE: wait for busy_i to go high, then low.
    - On the busy_i falling edge (registered busy_i 1→0), pulse done_o for one cycle.
    - Same transition: state EMPTY, counters zeroed, ld_ready_o=1.
    - busy_i low while never seen high keeps state SERVE.
- Row read, in all states:
  - Request in cycle N produces in cycle N+1: mat_row_valid_o=1, mat_row_addr_o=addr, mat_row_o = storage row addr.
  - Columns j > addr are forced to zero at output (no upper-triangle clear on load).
  - Back-to-back requests give back-to-back responses; valid low otherwise, and data holds its last value.
- Simultaneous load write and request to the same row (EMPTY only) returns the pre-write contents (read-before-write).
- Request while in EMPTY:
  - Still answered.
  - req_err_o set and held until reset/flush.
- flush_i (synchronous, any state):
  - Next cycle: state EMPTY, counters 0, start_o/done_o/mat_row_valid_o 0, req_err_o cleared, ld_ready_o 1.
  - A request in the flush cycle is dropped.
  - flush_i has priority over a load beat in the same cycle; that beat is not written.
- Reset asserted mid-load or mid-serve: immediate return to reset values; the partially loaded matrix is discarded (counters 0).
- No arithmetic beyond counters. Counters are $clog2(SIZE) bits, with no wrap past SIZE-1 because the transition fires at the final beat.

Test Plan:
- SIZE=4, reset then stream 10 beats, element (r,c) = {real (r*4+c), imag -(r*4+c)} as doubles → ld_ready_o drops after beat 10; start_o high exactly 1 cycle, 2 cycles after the last beat.
- After load, requests for addr 3,0,2 in consecutive cycles → three consecutive valid responses. Row 0 = {elem(0,0), 0, 0, 0}; row 3 has all 4 elements; addr echoed 3,0,2.
- In SERVE drive busy_i 0→1 for 20 cycles then 0 → done_o pulses 1 cycle after the fall; ld_ready_o=1 the same cycle; a second matrix loads correctly.
- Request addr 1 while in EMPTY after 3 beats → response has elem(1,0), elem(1,1), zeros; req_err_o=1 and stays 1 until flush_i.
- Assert flush_i at beat 6 with ld_valid_i high → beat not written; ld_ready_o=1 next cycle; a fresh 10-beat load produces start_o only after 10 new beats.
- Assert rst_i asynchronously mid-SERVE (between clock edges) → all outputs 0 immediately; ld_ready_o returns 1 on the first clock after release.
